// File: rtl/la_ring_capture.sv
// Single-clock logic-analyzer capture core with a circular pre-trigger buffer.
// Samples are decimated, stored circularly, and read back by logical index once a capture completes.
module la_ring_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic                     sample_valid,
    input  logic [WIDTH-1:0]         sample_data,
    input  logic                     ext_trigger,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     force_trig,
    input  logic [1:0]               cfg_mode,
    input  logic [$clog2(DEPTH)-1:0] cfg_pretrig,
    input  logic [WIDTH-1:0]         cfg_value,
    input  logic [WIDTH-1:0]         cfg_mask,
    input  logic [15:0]              cfg_decimate,
    output logic                     idle,
    output logic                     triggered,
    output logic                     done,
    output logic                     capture_valid,
    output logic [$clog2(DEPTH)-1:0] trig_addr,
    output logic [$clog2(DEPTH)-1:0] start_addr,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_index,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRE_FILL  = 2'd1,
        S_WAIT_TRIG = 2'd2,
        S_POST_FILL = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic [1:0]        mode_q, mode_d;
    logic [AW-1:0]     pretrig_q, pretrig_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [15:0]       decimate_q, decimate_d;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [15:0]       dec_cnt_q, dec_cnt_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              force_pend_q, force_pend_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              capture_valid_q, capture_valid_d;
    logic [AW-1:0]     trig_addr_q, trig_addr_d;
    logic [AW-1:0]     start_addr_q, start_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              capturing;
    logic              arm_go;
    logic              abort_go;
    logic              accept;
    logic              trig_hit;
    logic              fire;
    logic              complete;
    logic [AW-1:0]     post_len;
    logic [AW-1:0]     rd_addr;

    // Capture events shared by the FSM and the datapath.
    always_comb begin
        capturing = (state_q != S_IDLE);
        arm_go    = arm && !abort && (state_q == S_IDLE);
        abort_go  = abort && capturing;
        accept    = capturing && sample_valid && (dec_cnt_q == '0);
        post_len  = AW'(DEPTH - 1) - pretrig_q;
        rd_addr   = start_addr_q + rd_index;

        case (mode_q)
            2'd0:    trig_hit = ext_trigger;
            2'd1:    trig_hit = ((sample_data & mask_q) == (value_q & mask_q));
            2'd2:    trig_hit = prev_valid_q && (|(~prev_q & sample_data & mask_q));
            default: trig_hit = prev_valid_q && (|(prev_q & ~sample_data & mask_q));
        endcase

        fire     = (state_q == S_WAIT_TRIG) && accept && !abort
                   && (trig_hit || force_pend_q || force_trig);
        complete = (fire && (post_len == '0))
                   || ((state_q == S_POST_FILL) && accept && !abort && (cnt_q == AW'(1)));
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm_go) begin
                    state_d = (cfg_pretrig == '0) ? S_WAIT_TRIG : S_PRE_FILL;
                end
            end
            S_PRE_FILL: begin
                if (accept && (cnt_q + AW'(1) == pretrig_q)) begin
                    state_d = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (fire) begin
                    state_d = (post_len == '0) ? S_IDLE : S_POST_FILL;
                end
            end
            S_POST_FILL: begin
                if (complete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_go) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        idle          = (state_q == S_IDLE);
        triggered     = triggered_q;
        done          = done_q;
        capture_valid = capture_valid_q;
        trig_addr     = trig_addr_q;
        start_addr    = start_addr_q;
        rd_valid      = rd_valid_q;
        rd_data       = rd_data_q;
    end

    always_comb begin
        mode_d          = mode_q;
        pretrig_d       = pretrig_q;
        value_d         = value_q;
        mask_d          = mask_q;
        decimate_d      = decimate_q;
        wr_ptr_d        = wr_ptr_q;
        cnt_d           = cnt_q;
        dec_cnt_d       = dec_cnt_q;
        prev_d          = prev_q;
        prev_valid_d    = prev_valid_q;
        force_pend_d    = force_pend_q;
        triggered_d     = triggered_q;
        capture_valid_d = capture_valid_q;
        trig_addr_d     = trig_addr_q;
        start_addr_d    = start_addr_q;
        done_d          = complete;

        if (arm_go) begin
            mode_d          = cfg_mode;
            pretrig_d       = cfg_pretrig;
            value_d         = cfg_value;
            mask_d          = cfg_mask;
            decimate_d      = cfg_decimate;
            wr_ptr_d        = '0;
            cnt_d           = '0;
            dec_cnt_d       = '0;
            prev_valid_d    = 1'b0;
            force_pend_d    = 1'b0;
            capture_valid_d = 1'b0;
        end else if (capturing && !abort) begin
            if (sample_valid) begin
                dec_cnt_d = (dec_cnt_q == decimate_q) ? '0 : dec_cnt_q + 16'd1;
            end
            if (accept) begin
                wr_ptr_d     = wr_ptr_q + AW'(1);
                prev_d       = sample_data;
                prev_valid_d = 1'b1;
                if (state_q == S_PRE_FILL) begin
                    cnt_d = cnt_q + AW'(1);
                end
                if (state_q == S_POST_FILL) begin
                    cnt_d = cnt_q - AW'(1);
                end
                if (fire) begin
                    trig_addr_d  = wr_ptr_q;
                    start_addr_d = wr_ptr_q - pretrig_q;
                    cnt_d        = post_len;
                    triggered_d  = 1'b1;
                end
            end else if ((state_q == S_WAIT_TRIG) && force_trig) begin
                // A force with no sample to attach to waits for the next accepted one.
                force_pend_d = 1'b1;
            end
        end

        if (complete) begin
            capture_valid_d = 1'b1;
            triggered_d     = 1'b0;
        end
        if (abort_go) begin
            triggered_d = 1'b0;
        end

        rd_valid_d = rd_en && (state_q == S_IDLE) && capture_valid_q;
        rd_data_d  = rd_valid_d ? mem[rd_addr] : rd_data_q;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            mode_q          <= '0;
            pretrig_q       <= '0;
            value_q         <= '0;
            mask_q          <= '0;
            decimate_q      <= '0;
            wr_ptr_q        <= '0;
            cnt_q           <= '0;
            dec_cnt_q       <= '0;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            force_pend_q    <= 1'b0;
            triggered_q     <= 1'b0;
            done_q          <= 1'b0;
            capture_valid_q <= 1'b0;
            trig_addr_q     <= '0;
            start_addr_q    <= '0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            mode_q          <= mode_d;
            pretrig_q       <= pretrig_d;
            value_q         <= value_d;
            mask_q          <= mask_d;
            decimate_q      <= decimate_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt_q           <= cnt_d;
            dec_cnt_q       <= dec_cnt_d;
            prev_q          <= prev_d;
            prev_valid_q    <= prev_valid_d;
            force_pend_q    <= force_pend_d;
            triggered_q     <= triggered_d;
            done_q          <= done_d;
            capture_valid_q <= capture_valid_d;
            trig_addr_q     <= trig_addr_d;
            start_addr_q    <= start_addr_d;
            rd_valid_q      <= rd_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    // Sample storage has no reset so it can map onto block RAM.
    always_ff @(posedge pclk) begin
        if (accept && !abort) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

endmodule

// File: tb/tb_la_ring_capture.sv
// Bench for la_ring_capture: randomized and directed captures against a sample-list model.
module tb_la_ring_capture;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  sample_data = '0;
    logic          ext_trigger = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [AW-1:0] cfg_pretrig = '0;
    logic [W-1:0]  cfg_value = '0;
    logic [W-1:0]  cfg_mask = '0;
    logic [15:0]   cfg_decimate = '0;
    logic          idle, triggered, done, capture_valid;
    logic [AW-1:0] trig_addr, start_addr;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_index = '0;
    logic          rd_valid;
    logic [W-1:0]  rd_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] tbl [4];

    la_ring_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .pclk(pclk), .preset_n(preset_n), .sample_valid(sample_valid), .sample_data(sample_data),
        .ext_trigger(ext_trigger), .arm(arm), .abort(abort), .force_trig(force_trig),
        .cfg_mode(cfg_mode), .cfg_pretrig(cfg_pretrig), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
        .cfg_decimate(cfg_decimate), .idle(idle), .triggered(triggered), .done(done),
        .capture_valid(capture_valid), .trig_addr(trig_addr), .start_addr(start_addr),
        .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // kind: 0 incrementing, 1 random, 2 table then random. ext_at<0 gives random ext pulses.
    task automatic do_capture(input int mode, input logic [7:0] val, input logic [7:0] mask,
                              input int pre, input int dec, input int kind, input int vprob,
                              input int ext_at, input int fa, input int fb, input bit noise);
        logic [7:0] acc[$];
        logic [7:0] prev;
        logic [7:0] d;
        int  mcnt, vcnt, tidx, cyc, idx;
        bit  fpend, pok, fin, v, e, f, acc_now, waiting, cond;
        mcnt = 0; vcnt = 0; tidx = -1; cyc = 0;
        fpend = 0; pok = 0; fin = 0; prev = '0;

        cfg_mode = 2'(mode); cfg_value = val; cfg_mask = mask;
        cfg_pretrig = AW'(pre); cfg_decimate = 16'(dec);
        arm = 1'b1; sample_valid = 1'b1; sample_data = 8'hEE; ext_trigger = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("arm_leaves_idle", idle, 0);
        check_eq("arm_clears_cv", capture_valid, 0);

        while (!fin && cyc < 3000) begin
            v = ($urandom_range(99) < vprob);
            f = (cyc == fa) || (cyc == fb);
            if (f) v = 0;
            case (kind)
                0:       d = 8'(vcnt);
                1:       d = 8'($urandom);
                default: d = (vcnt < 4) ? tbl[vcnt] : 8'($urandom);
            endcase
            e = (ext_at >= 0) ? (v && (int'(d) == ext_at)) : ($urandom_range(29) == 0);
            sample_valid = v; sample_data = d; ext_trigger = e; force_trig = f;
            arm = noise && ($urandom_range(15) == 0);
            if (noise) begin
                cfg_mode = 2'($urandom); cfg_value = 8'($urandom); cfg_mask = 8'($urandom);
                cfg_pretrig = AW'($urandom); cfg_decimate = 16'($urandom);
            end

            waiting = (mcnt >= pre) && (tidx < 0);
            acc_now = v && ((vcnt % (dec + 1)) == 0);
            if (v) vcnt++;
            if (acc_now) begin
                acc.push_back(d);
                if (waiting) begin
                    case (mode)
                        0:       cond = e;
                        1:       cond = ((d & mask) == (val & mask));
                        2:       cond = pok && ((~prev & d & mask) != 0);
                        default: cond = pok && ((prev & ~d & mask) != 0);
                    endcase
                    if (cond || fpend) tidx = mcnt;
                end
                prev = d; pok = 1; mcnt++;
                if (tidx >= 0 && mcnt == tidx + D - pre) fin = 1;
            end else if (waiting && f) begin
                fpend = 1;
            end

            tick();
            check_eq("done", done, fin);
            check_eq("idle", idle, fin);
            check_eq("triggered", triggered, (tidx >= 0) && !fin);
            cyc++;
        end
        sample_valid = 0; force_trig = 0; arm = 0; ext_trigger = 0;
        if (!fin) check_eq("capture_timeout", 0, 1);

        tick();
        check_eq("done_one_cycle", done, 0);
        if (fin) begin
            check_eq("capture_valid", capture_valid, 1);
            check_eq("trig_addr", trig_addr, 64'(tidx % D));
            check_eq("start_addr", start_addr, 64'((tidx - pre) % D));
            for (int i = 0; i < D; i++) begin
                idx = noise ? int'($urandom_range(D - 1)) : i;
                rd_en = 1'b1; rd_index = AW'(idx);
                tick();
                check_eq("rd_valid", rd_valid, 1);
                check_eq("rd_data", rd_data, acc[tidx - pre + idx]);
            end
            rd_en = 1'b0;
            tick();
            check_eq("rd_valid_drop", rd_valid, 0);
            check_eq("rd_data_held", rd_data, acc[tidx - pre + idx]);
        end
    endtask

    task automatic step_sample(input logic [7:0] d, input logic e);
        sample_valid = 1'b1; sample_data = d; ext_trigger = e;
        tick();
        sample_valid = 1'b0; ext_trigger = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = 8'h01; tbl[1] = 8'h01; tbl[2] = 8'h00; tbl[3] = 8'h01;
        repeat (2) tick();
        check_eq("rst_idle", idle, 1);
        check_eq("rst_triggered", triggered, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cv", capture_valid, 0);
        check_eq("rst_trig_addr", trig_addr, 0);
        check_eq("rst_start_addr", start_addr, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        preset_n = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("rd_no_capture", rd_valid, 0);

        // Pattern 0x55 on an incrementing stream.
        do_capture(1, 8'h55, 8'hFF, 4, 0, 0, 100, -1, -1, -1, 0);
        // Rising edge with no fire on the first sample.
        do_capture(2, 8'h00, 8'h01, 0, 0, 2, 100, -1, -1, -1, 0);
        // Decimate by 3, external trigger on sample 30.
        do_capture(0, 8'h00, 8'h00, 3, 2, 0, 100, 30, -1, -1, 0);
        // Trigger after 100 accepted samples with gaps in sample_valid.
        do_capture(0, 8'h00, 8'h00, 4, 0, 0, 70, 100, -1, -1, 0);
        // Force in pre-fill is ignored; force with no valid sample waits.
        do_capture(3, 8'h00, 8'h00, 6, 0, 1, 100, -1, 2, 20, 0);
        // Maximum pre-trigger: capture completes on the trigger sample.
        do_capture(0, 8'h00, 8'h00, 15, 0, 1, 80, -1, 300, -1, 0);

        // Abort in post-fill, arm ignored while waiting, arm+abort in idle.
        cfg_mode = 2'd0; cfg_pretrig = 4'd2; cfg_decimate = 16'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        check_eq("ab_arm_cv", capture_valid, 0);
        step_sample(8'h10, 1'b0);
        step_sample(8'h11, 1'b0);
        arm = 1'b1; step_sample(8'h12, 1'b0); arm = 1'b0;
        check_eq("ab_arm_ignored", idle, 0);
        step_sample(8'h13, 1'b1);
        check_eq("ab_triggered", triggered, 1);
        check_eq("ab_trig_addr", trig_addr, 3);
        step_sample(8'h14, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("ab_idle", idle, 1);
        check_eq("ab_trig_clr", triggered, 0);
        check_eq("ab_no_done", done, 0);
        check_eq("ab_cv", capture_valid, 0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check_eq("ab_rd_valid", rd_valid, 0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check_eq("arm_abort_idle", idle, 1);
        tick();
        check_eq("arm_abort_idle2", idle, 1);

        // Reset in the middle of post-fill.
        do_capture(1, 8'hA5, 8'hFF, 2, 0, 1, 100, -1, 200, -1, 1);
        cfg_mode = 2'd0; cfg_pretrig = 4'd2; cfg_decimate = 16'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        step_sample(8'h20, 1'b0);
        step_sample(8'h21, 1'b0);
        step_sample(8'h22, 1'b1);
        step_sample(8'h23, 1'b0);
        check_eq("pre_rst_triggered", triggered, 1);
        preset_n = 1'b0;
        #1;
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_triggered", triggered, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_cv", capture_valid, 0);
        check_eq("mid_rst_trig_addr", trig_addr, 0);
        check_eq("mid_rst_start_addr", start_addr, 0);
        check_eq("mid_rst_rd_data", rd_data, 0);
        tick();
        preset_n = 1'b1;
        tick();

        for (int n = 0; n < 6; n++) begin
            do_capture(int'($urandom_range(3)), 8'($urandom), 8'($urandom),
                       int'($urandom_range(15)), int'($urandom_range(2)), 1,
                       int'($urandom_range(100, 50)), -1, 400, -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/la_ring_capture.md
Name: la_ring_capture

Overview:
Parametrised successor to the logic-analyzer capture engine: a single-clock waveform capture core with a true circular pre-trigger buffer. It supports programmable pre-trigger depth, four trigger modes (external/pattern/rising/falling), sample decimation, force-trigger and abort. It sits behind an APB register front-end, which drives its config and arm/abort pulses and reads samples back by logical index.

Parameters:
WIDTH, 32, sample width in bits (1..64)
DEPTH, 1024, buffer depth in samples; power of two, >=4; ADDR_BITS = clog2(DEPTH)

Ports:
pclk  in  1  clock
preset_n  in  1  asynchronous active-low reset
sample_valid  in  1  sample_data valid this cycle
sample_data  in  WIDTH  input sample
ext_trigger  in  1  external trigger, qualified with sample_valid
arm  in  1  one-cycle arm request
abort  in  1  one-cycle abort request
force_trig  in  1  one-cycle forced trigger
cfg_mode  in  2  0=ext, 1=pattern, 2=rising, 3=falling
cfg_pretrig  in  ADDR_BITS  samples kept before trigger
cfg_value  in  WIDTH  pattern value
cfg_mask  in  WIDTH  pattern/edge bit mask
cfg_decimate  in  16  keep 1 of every N+1 valid samples
idle  out  1  state==IDLE
triggered  out  1  trigger seen, post-fill in progress
done  out  1  one-cycle capture-complete pulse
capture_valid  out  1  buffer holds a complete capture
trig_addr  out  ADDR_BITS  physical address of trigger sample
start_addr  out  ADDR_BITS  physical address of oldest sample
rd_en  in  1  read request
rd_index  in  ADDR_BITS  logical index (0 = oldest sample)
rd_valid  out  1  rd_data valid
rd_data  out  WIDTH  read data

Behaviour:
- Reset: state IDLE; idle=1; triggered=0; done=0; capture_valid=0; trig_addr=0; start_addr=0; rd_valid=0; rd_data=0; wr_ptr/counters=0. Buffer contents are not reset.
- States: IDLE -> PRE_FILL -> WAIT_TRIG -> POST_FILL -> IDLE.
- arm in IDLE: latch all cfg_* inputs; clear wr_ptr, count, decimation counter, prev_valid and capture_valid. Next cycle: PRE_FILL, or WAIT_TRIG if cfg_pretrig==0. A sample coincident with arm is not captured.
- arm outside IDLE is ignored. abort in any non-IDLE state -> IDLE, no done, capture_valid stays 0. If arm and abort coincide, abort wins (the arm is dropped).
- Accept: sample_valid && dec_cnt==0. dec_cnt counts sample_valid cycles modulo decimate+1, so the first valid sample after arm is accepted. Each accepted sample writes mem[wr_ptr], then wr_ptr increments modulo DEPTH.
- PRE_FILL: write accepted samples. After cfg_pretrig accepted samples -> WAIT_TRIG. Triggers and force_trig are ignored in this state.
- WAIT_TRIG: keep writing circularly; overwriting old pre-trigger data is intended. The trigger condition is evaluated on each accepted sample:
  - mode 0: ext_trigger
  - mode 1: (data & mask) == (value & mask)
  - mode 2: |(~prev & data & mask)
  - mode 3: |(prev & ~data & mask)
  - Edge modes never fire on the first accepted sample after arm (prev_valid=0).
  - force_trig high in any WAIT_TRIG cycle fires on that cycle's accepted sample, or is held until the next accepted sample.
- On trigger: the trigger sample is written at wr_ptr. trig_addr <= wr_ptr; start_addr <= wr_ptr - pretrig (mod DEPTH); triggered=1; post_remaining = DEPTH-1-pretrig; state POST_FILL. If post_remaining==0, complete immediately.
- POST_FILL: write accepted samples until post_remaining reaches 0. The cycle after the last write: done=1 for one cycle, capture_valid=1, triggered=0, state IDLE.
- Total stored per capture is exactly DEPTH samples: pretrig before the trigger, the trigger sample, and the rest after it.
- Readout:
  - Only when IDLE && capture_valid.
  - Physical address = start_addr + rd_index (mod DEPTH).
  - rd_valid=1 and rd_data exactly 1 cycle after rd_en. Back-to-back reads are allowed, one per cycle.
  - rd_en otherwise gives rd_valid=0 and rd_data held.
- trig_addr and start_addr remain stable until the next successful trigger. The latched config is unaffected by cfg_* changes mid-capture.
- Reset mid-capture returns to the reset state at once, with no done.

Test Plan:
1. WIDTH=8, DEPTH=16, mode1, value=0x55, mask=0xFF, pretrig=4, decimate=0; incrementing stream from 0x00 -> trigger on 0x55, done 1 cycle after sample 0x60; rd_index 0..15 returns 0x51..0x60; index 4 = 0x55.
2. mode2, mask=0x01, pretrig=0; stream 0x01,0x01,0x00,0x01 -> no fire on first sample; trigger on 4th sample; rd_index 0 = 0x01; start_addr = trig_addr.
3. decimate=2, pretrig=3, mode0; stream 0,1,2,..., ext_trigger on sample 30 -> ext_trigger is seen on accepted sample 30 (only every 3rd valid sample is accepted); readback 21,24,27,30,33,...
4. pretrig=4, trigger after 100 accepted samples -> wr_ptr has wrapped; start_addr = (trig_addr-4) mod 16; logical readback is continuous with no discontinuity.
5. abort in POST_FILL -> idle next cycle, no done, capture_valid=0, rd_en gives rd_valid=0. arm during WAIT_TRIG is ignored. arm+abort in IDLE leaves the state IDLE.
6. force_trig pulsed in PRE_FILL is ignored; pulsed in WAIT_TRIG with sample_valid=0 -> fires on the next valid sample. preset_n low mid-POST_FILL -> all outputs at reset values immediately.
